logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the 8-bit bitwise OR gate in the ALU datapath.
- Performs one of eight bitwise operations on two WIDTH-bit operands and produces zero, parity and all-ones flags.
- Has one output register stage with a valid/ready handshake, so it can sit between the ALU operand-select logic and the result write-back mux under backpressure.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operand transaction offered.
- in_ready  output  1  block can accept a transaction this cycle.
- in_op  input  3  operation select (see Behaviour).
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream accepts the result this cycle.
- out_y  output  WIDTH  registered result.
- out_zero  output  1  out_y == 0.
- out_parity  output  1  XOR-reduction of out_y.
- out_ones  output  1  out_y is all ones.

Behaviour:
- Reset: rst_n sampled low at a rising edge clears out_valid, out_y, out_zero, out_parity and out_ones to 0.
- Reset mid-operation discards any held result. in_ready is 1 in the first cycle after reset release.
- Operation encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NOR
  - 100 NAND, 101 XNOR, 110 NOT A (B ignored), 111 PASS A (B ignored)
- Handshake:
  - Accept happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational). No other combinational in->out path exists.
- Latency and throughput:
  - Latency is 1 cycle: an operand accepted at edge N has its result and flags visible on out_* after edge N.
  - Throughput is 1 transaction per cycle while out_ready stays high.
- Register update rules:
  - On accept: out_y, flags and out_valid=1 are loaded together.
  - On output transfer with no accept in the same cycle: out_valid goes to 0; out_y and flags hold their last values.
  - Simultaneous transfer and accept: the new result replaces the old one and out_valid stays 1.
- Stall: out_valid && !out_ready holds out_y and flags stable, drives in_ready to 0, and ignores inputs.
- Flags are computed from the new result before registering, so they always match out_y.
- in_op, in_a and in_b are don't-care when in_valid is 0.

Optional Feature:
- Macro LOGIC_UNIT_ACCUM_EN.
- When defined:
  - Add input port in_accum (1 bit) and an internal WIDTH-bit accumulator, reset to 0.
  - On an accept with in_accum=1, operand B is replaced by the accumulator value.
  - Every accept loads the accumulator with the new result, whatever in_accum is.
  - A stall does not change the accumulator.
  - This enables chained reductions, e.g. successive ORs of a stream.
- When undefined: no in_accum port, no accumulator, operand B is always in_b.

Decomposition:
- Package logic_unit_pkg holds:
  - the op enum type lu_op_e (3 bits, encodings above);
  - constants LU_OP_W=3 and LU_DEFAULT_WIDTH=8;
  - a function lu_parity (XOR-reduce).
- Sub-module lu_bitwise_core is the purely combinational op mux: WIDTH-bit a, b, op in; y, zero, parity, ones out.
- logic_unit_pipe instantiates lu_bitwise_core and owns the handshake, the result register and the optional accumulator.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_y=0x00 and all flags 0 after reset; in_ready=1 after release.
- Op sweep, WIDTH=8, out_ready=1: a=0xA5, b=0x3C for ops 000..111 -> out_y = 0x24, 0xBD, 0x99, 0x42, 0xDB, 0x66, 0x5A, 0xA5 on consecutive cycles, latency 1.
- Flags: a=0x0F, b=0xF0:
  - XOR -> out_y=0xFF, ones=1, zero=0, parity=0;
  - AND -> out_y=0x00, zero=1.
- Backpressure: out_ready=0 for 3 cycles after an accept (a=0x81, b=0x18, OR) -> out_y holds 0x99, in_ready=0, and a new input offered during the stall is not taken. Raise out_ready -> the new input is accepted in the same cycle; no loss, no duplication.
- Reset mid-stall: out_valid=1, out_ready=0, pulse rst_n low for one edge -> out_valid=0 and out_y=0 on the next cycle; the held result is never delivered.
- LOGIC_UNIT_ACCUM_EN defined: OR with in_accum=1 and a = 0x01, 0x04, 0x10 in sequence -> out_y = 0x01, 0x05, 0x15. A stall between the second and third op leaves the accumulator at 0x05.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared types and helpers for the registered bitwise logic unit.
// The LOGIC_UNIT_ACCUM_EN build option is handled in logic_unit_pipe.
package logic_unit_pkg;

    localparam int unsigned LU_OP_W          = 3;
    localparam int unsigned LU_DEFAULT_WIDTH = 8;

    typedef enum logic [LU_OP_W-1:0] {
        OpAnd  = 3'b000,
        OpOr   = 3'b001,
        OpXor  = 3'b010,
        OpNor  = 3'b011,
        OpNand = 3'b100,
        OpXnor = 3'b101,
        OpNotA = 3'b110,
        OpPass = 3'b111
    } lu_op_e;

    // Callers zero-extend narrower values, which leaves the XOR-reduction unchanged.
    function automatic logic lu_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/logic_unit_pipe_core.sv
// Purely combinational bitwise op mux with zero/parity/all-ones flags.
module lu_bitwise_core
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = LU_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [LU_OP_W-1:0] op,
    output logic [WIDTH-1:0]   y,
    output logic               zero,
    output logic               parity,
    output logic               ones
);

    always_comb begin
        y = '0;
        unique case (lu_op_e'(op))
            OpAnd:   y = a & b;
            OpOr:    y = a | b;
            OpXor:   y = a ^ b;
            OpNor:   y = ~(a | b);
            OpNand:  y = ~(a & b);
            OpXnor:  y = ~(a ^ b);
            OpNotA:  y = ~a;
            OpPass:  y = a;
            default: y = '0;
        endcase
    end

    always_comb begin
        zero   = (y == '0);
        ones   = &y;
        parity = lu_parity(64'(y));
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with one registered output stage and valid/ready handshake.
// Define LOGIC_UNIT_ACCUM_EN to add the in_accum port and a result accumulator.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = LU_DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef LOGIC_UNIT_ACCUM_EN
    input  logic               in_accum,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LU_OP_W-1:0] in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_y,
    output logic               out_zero,
    output logic               out_parity,
    output logic               out_ones
);

    logic             accept;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] y_d;
    logic             zero_d;
    logic             parity_d;
    logic             ones_d;

    logic             valid_q;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;
    logic             parity_q;
    logic             ones_q;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef LOGIC_UNIT_ACCUM_EN
    logic [WIDTH-1:0] acc_q;

    assign b_sel = in_accum ? acc_q : in_b;

    // Every accept reloads the accumulator, so chains restart on any in_accum=0 op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= y_d;
        end
    end
`else
    assign b_sel = in_b;
`endif

    lu_bitwise_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (in_a),
        .b      (b_sel),
        .op     (in_op),
        .y      (y_d),
        .zero   (zero_d),
        .parity (parity_d),
        .ones   (ones_d)
    );

    // Data and flags only move on accept; a bare transfer just drops valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            y_q      <= '0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
            ones_q   <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            y_q      <= y_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
            ones_q   <= ones_d;
        end else if (valid_q && out_ready) begin
            valid_q  <= 1'b0;
        end
    end

    assign out_valid  = valid_q;
    assign out_y      = y_q;
    assign out_zero   = zero_q;
    assign out_parity = parity_q;
    assign out_ones   = ones_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe; the driver queues expected results on accept
// and a negedge monitor checks each output transfer against the queue.
module tb_logic_unit_pipe;

    typedef struct packed {
        logic [7:0] y;
        logic       z;
        logic       p;
        logic       o;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       out_zero;
    logic       out_parity;
    logic       out_ones;
`ifdef LOGIC_UNIT_ACCUM_EN
    logic       in_accum;
`endif

    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    logic_unit_pipe #(
        .WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef LOGIC_UNIT_ACCUM_EN
        .in_accum   (in_accum),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_zero   (out_zero),
        .out_parity (out_parity),
        .out_ones   (out_ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] y);
        exp_t e;
        e.y = y;
        e.z = (y == 8'h00);
        e.p = ^y;
        e.o = (y == 8'hFF);
        return e;
    endfunction

    // Call just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic acc, input logic [7:0] exp_y);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
`ifdef LOGIC_UNIT_ACCUM_EN
        in_accum = acc;
`else
        if (acc) $display("note: accumulate request ignored in this build");
`endif
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end else begin
            sb.push_back(mk(exp_y));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (got) check("latency_out_valid", 64'(out_valid), 64'd1);
    endtask

    // Monitor: a transfer happens at the next posedge whenever valid && ready here.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got y=0x%0h, expected no output", out_y);
                end else begin
                    e = sb.pop_front();
                    check("out_y", 64'(out_y), 64'(e.y));
                    check("out_zero", 64'(out_zero), 64'(e.z));
                    check("out_parity", 64'(out_parity), 64'(e.p));
                    check("out_ones", 64'(out_ones), 64'(e.o));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'b001;
        in_a      = 8'hFF;
        in_b      = 8'hFF;
        out_ready = 1'b1;
`ifdef LOGIC_UNIT_ACCUM_EN
        in_accum  = 1'b0;
`endif

        // Reset with in_valid asserted.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_y", 64'(out_y), 64'h00);
        check("rst_flags", 64'({out_zero, out_parity, out_ones}), 64'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

`ifdef LOGIC_UNIT_ACCUM_EN
        // Accumulator is 0 after reset; a stall sits between the 2nd and 3rd op.
        send(3'b001, 8'h01, 8'hEE, 1'b1, 8'h01);
        send(3'b001, 8'h04, 8'hEE, 1'b1, 8'h05);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'b001;
        in_a      = 8'h10;
        in_b      = 8'hEE;
        in_accum  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("acc_stall_hold", 64'(out_y), 64'h05);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(3'b001, 8'h10, 8'hEE, 1'b1, 8'h15);
        in_accum = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`endif

        // Op sweep, back to back.
        send(3'b000, 8'hA5, 8'h3C, 1'b0, 8'h24);
        send(3'b001, 8'hA5, 8'h3C, 1'b0, 8'hBD);
        send(3'b010, 8'hA5, 8'h3C, 1'b0, 8'h99);
        send(3'b011, 8'hA5, 8'h3C, 1'b0, 8'h42);
        send(3'b100, 8'hA5, 8'h3C, 1'b0, 8'hDB);
        send(3'b101, 8'hA5, 8'h3C, 1'b0, 8'h66);
        send(3'b110, 8'hA5, 8'h3C, 1'b0, 8'h5A);
        send(3'b111, 8'hA5, 8'h3C, 1'b0, 8'hA5);

        // Flag corners: all ones (even parity) and all zeros.
        send(3'b010, 8'h0F, 8'hF0, 1'b0, 8'hFF);
        send(3'b000, 8'h0F, 8'hF0, 1'b0, 8'h00);

        // Backpressure: stall three cycles with a new op pending.
        send(3'b001, 8'h81, 8'h18, 1'b0, 8'h99);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'b000;
        in_a      = 8'hF0;
        in_b      = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_y", 64'(out_y), 64'h99);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(3'b000, 8'hF0, 8'h3C, 1'b0, 8'h30);
        repeat (3) @(posedge clk);
        #1;
        check("drained_out_valid", 64'(out_valid), 64'd0);

        // Reset while a result is held under stall.
        send(3'b010, 8'h12, 8'h34, 1'b0, 8'h26);
        out_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_held", 64'(out_y), 64'h26);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_y", 64'(out_y), 64'h00);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_delivery", 64'(out_valid), 64'd0);

        // One more transaction after reset to confirm normal operation resumes.
        send(3'b011, 8'h00, 8'h00, 1'b0, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
